// File: rtl/fwgpio_reg_initiator_if.sv
// Command/response streams and RV initiator bus
// of the fwgpio register-access initiator.
interface fwgpio_reg_initiator_if #(
  parameter int ADR_WIDTH = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADR_WIDTH-1:0] cmd_adr;
  logic                 cmd_we;
  logic [31:0]          cmd_dat;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_dat;
  logic                 rsp_err;
  logic [ADR_WIDTH-1:0] ri_adr;
  logic [31:0]          ri_dat_w;
  logic [31:0]          ri_dat_r;
  logic                 ri_we;
  logic                 ri_valid;
  logic                 ri_ready;

  modport master (
    input  cmd_valid,
    input  cmd_adr,
    input  cmd_we,
    input  cmd_dat,
    input  rsp_ready,
    input  ri_dat_r,
    input  ri_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_dat,
    output rsp_err,
    output ri_adr,
    output ri_dat_w,
    output ri_we,
    output ri_valid
  );

  modport slave (
    output cmd_valid,
    output cmd_adr,
    output cmd_we,
    output cmd_dat,
    output rsp_ready,
    output ri_dat_r,
    output ri_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_dat,
    input  rsp_err,
    input  ri_adr,
    input  ri_dat_w,
    input  ri_we,
    input  ri_valid
  );
endinterface

// File: rtl/fwgpio_reg_initiator.sv
// Queued register-access initiator: one bus access at a time,
// one response per access, bounded by a per-access timeout.
module fwgpio_reg_initiator #(
  parameter int ADR_WIDTH      = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fwgpio_reg_initiator_if.master bus,
  output logic                   busy
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AW:0] FULL = (AW+1)'(CMD_DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [ADR_WIDTH-1:0] adr;
    logic                 we;
    logic [31:0]          dat;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_t;

  cmd_t          mem [CMD_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tmo_q;
  logic          bus_ack;
  logic          bus_tmo;

  // Ready comes from the registered count only, so a full FIFO
  // refuses a push even when it pops on the same edge.
  assign bus.cmd_ready = (count != FULL);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign head = mem[rd_ptr];
  assign busy = (count != '0) || (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_adr, bus.cmd_we, bus.cmd_dat};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count != '0) state_d = BUS;
      BUS:  if (bus_ack || bus_tmo) state_d = RSP;
      RSP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    bus_ack = 1'b0;
    bus_tmo = 1'b0;
    unique case (state_q)
      IDLE: pop = (count != '0);
      BUS: begin
        bus_ack = bus.ri_ready;
        bus_tmo = !bus.ri_ready && (tmo_q == TMAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ri_adr    <= '0;
      bus.ri_we     <= 1'b0;
      bus.ri_dat_w  <= '0;
      bus.ri_valid  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
      tmo_q         <= '0;
    end else begin
      if (pop) begin
        bus.ri_adr   <= head.adr;
        bus.ri_we    <= head.we;
        bus.ri_dat_w <= head.dat;
        bus.ri_valid <= 1'b1;
        tmo_q        <= '0;
      end else if (state_q == BUS) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (bus_ack || bus_tmo) begin
        bus.ri_valid  <= 1'b0;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= bus_tmo;
        bus.rsp_dat   <= (bus_ack && !bus.ri_we)
                         ? bus.ri_dat_r : 32'h0;
      end
      if (state_q == RSP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fwgpio_reg_initiator.sv
// Directed bench for fwgpio_reg_initiator with a GPIO-like
// register target model and an in-order response scoreboard.
module tb_fwgpio_reg_initiator;
  localparam int AW = 4;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clock = ~clock;

  fwgpio_reg_initiator_if #(.ADR_WIDTH(AW)) bus ();

  fwgpio_reg_initiator #(
    .ADR_WIDTH(AW),
    .CMD_DEPTH(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  // Target: answers one cycle after it samples ri_valid.
  logic [31:0] tregs [16] = '{default: 32'h0};
  logic        tgt_rdy = 1'b0;
  logic        tgt_en;
  logic        stale;

  assign bus.ri_ready = tgt_rdy | stale;

  always @(posedge clock) begin
    if (tgt_en && bus.ri_valid && !tgt_rdy) begin
      tgt_rdy <= 1'b1;
      if (bus.ri_we) tregs[bus.ri_adr] <= bus.ri_dat_w;
      bus.ri_dat_r <= bus.ri_we ? 32'h0 : tregs[bus.ri_adr];
    end else begin
      tgt_rdy <= 1'b0;
      bus.ri_dat_r <= 32'hDEAD_BEEF;
    end
  end

  int checks = 0;
  int passes = 0;
  int rsp_cnt = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [31:0] shadow [16];
  int rises[$];
  int hi_lens[$];
  int low_run = 0;
  int hi_run = 0;
  int min_low = 1000;
  logic prev_riv = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_dat", bus.rsp_dat, e.dat);
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
      end
    end
    if (bus.ri_valid && !prev_riv) begin
      rises.push_back(cyc);
      if (rises.size() > 1 && low_run < min_low) min_low = low_run;
    end
    if (bus.ri_valid) begin
      hi_run++;
      low_run = 0;
    end else begin
      if (prev_riv) hi_lens.push_back(hi_run);
      hi_run = 0;
      low_run++;
    end
    prev_riv = bus.ri_valid;
  end

  // Called and returns at posedge+1; drops cmd_valid once accepted.
  task automatic push(input logic [3:0] adr, input logic we,
                      input logic [31:0] dat,
                      input logic [31:0] ed, input logic ee);
    bit ok;
    ok = 1'b0;
    bus.cmd_adr   = adr;
    bus.cmd_we    = we;
    bus.cmd_dat   = dat;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = bus.cmd_ready;
      @(posedge clock);
    end
    if (ok) sb.push_back('{ed, ee});
    chk("cmd_accept", {31'b0, ok}, 32'd1);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    shadow[adr] = dat;
    push(adr, 1'b1, dat, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] adr);
    push(adr, 1'b0, 32'h0, shadow[adr], 1'b0);
  endtask

  task automatic rd_to(input logic [3:0] adr);
    push(adr, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy && !bus.rsp_valid) break;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_we    = 1'b0;
    bus.cmd_dat   = '0;
    bus.rsp_ready = 1'b1;
    stale  = 1'b0;
    tgt_en = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;

    repeat (2) @(negedge clock);
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_ri_valid", {31'b0, bus.ri_valid}, 32'd0);
    chk("rst_ri_we", {31'b0, bus.ri_we}, 32'd0);
    chk("rst_ri_adr", 32'(bus.ri_adr), 32'd0);
    chk("rst_ri_dat_w", bus.ri_dat_w, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Write then read back, with first-access latency.
    wr(4'h2, 32'h0000_0700);
    chk("lat_a0_ri_valid", {31'b0, bus.ri_valid}, 32'd0);
    @(posedge clock); #1;
    chk("lat_a1_ri_valid", {31'b0, bus.ri_valid}, 32'd1);
    chk("lat_a1_ri_adr", 32'(bus.ri_adr), 32'h2);
    chk("lat_a1_ri_dat_w", bus.ri_dat_w, 32'h0000_0700);
    @(posedge clock); #1;
    chk("lat_a2_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clock); #1;
    chk("lat_a3_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    drain("drain_wr");
    rd(4'h2);
    drain("drain_rd");

    // Timeout, then the next queued command runs normally.
    tgt_en = 1'b0;
    hi_lens.delete();
    rd_to(4'h5);
    rd(4'h2);
    for (int i = 0; i < 60 && hi_lens.size() == 0; i++)
      @(negedge clock);
    tgt_en = 1'b1;
    chk("tmo_seen", 32'(hi_lens.size()), 32'd1);
    if (hi_lens.size() > 0)
      chk("tmo_ri_valid_len", 32'(hi_lens[0]), 32'(TO));
    drain("drain_tmo");

    // Back-pressure fills the FIFO; order kept on release.
    bus.rsp_ready = 1'b0;
    wr(4'h3, 32'h0000_0011);
    wr(4'h4, 32'h0000_0022);
    rd(4'h3);
    rd(4'h4);
    rd(4'h2);
    @(negedge clock);
    chk("full_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("full_busy", {31'b0, busy}, 32'd1);
    n = rsp_cnt;
    repeat (5) @(negedge clock);
    chk("bp_rsp_held", {31'b0, bus.rsp_valid}, 32'd1);
    chk("bp_still_full", {31'b0, bus.cmd_ready}, 32'd0);
    chk("bp_rsp_cnt", 32'(rsp_cnt), 32'(n));
    @(posedge clock);
    #1 bus.rsp_ready = 1'b1;
    drain("drain_bp");
    chk("bp_rsp_total", 32'(rsp_cnt), 32'(n + 5));

    // Stale ri_ready in IDLE and in RSP.
    n = rsp_cnt;
    stale = 1'b1;
    @(posedge clock); #1 stale = 1'b0;
    repeat (3) @(negedge clock);
    chk("stale_idle_cnt", 32'(rsp_cnt), 32'(n));
    chk("stale_idle_busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    rd(4'h3);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++)
      @(negedge clock);
    @(posedge clock); #1 stale = 1'b1;
    @(posedge clock); #1 stale = 1'b0;
    repeat (3) @(negedge clock);
    chk("stale_rsp_held", {31'b0, bus.rsp_valid}, 32'd1);
    @(posedge clock);
    #1 bus.rsp_ready = 1'b1;
    drain("drain_stale");
    repeat (3) @(negedge clock);
    chk("stale_rsp_cnt", 32'(rsp_cnt), 32'(n + 1));

    // Async reset in the middle of a bus access.
    @(posedge clock); #1;
    tgt_en = 1'b0;
    rd(4'h4);
    rd(4'h5);
    rd(4'h6);
    for (int i = 0; i < 20 && !bus.ri_valid; i++)
      @(negedge clock);
    chk("rstm_pre_ri_valid", {31'b0, bus.ri_valid}, 32'd1);
    n = rsp_cnt;
    #2 reset = 1'b1;
    #1;
    chk("rstm_ri_valid", {31'b0, bus.ri_valid}, 32'd0);
    chk("rstm_busy", {31'b0, busy}, 32'd0);
    chk("rstm_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    sb.delete();
    tgt_en = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("rstm_fifo_empty", {31'b0, busy}, 32'd0);
    chk("rstm_no_rsp", 32'(rsp_cnt), 32'(n));
    @(posedge clock); #1;
    rd(4'h2);
    drain("drain_rstm");

    // Streamed reads: one access every 4 cycles.
    rises.delete();
    min_low = 1000;
    for (int i = 0; i < 8; i++) rd(4'(i));
    drain("drain_stream");
    chk("stream_accesses", 32'(rises.size()), 32'd8);
    for (int k = 1; k < rises.size(); k++)
      chk("stream_period", 32'(rises[k] - rises[k-1]), 32'd4);
    chk("stream_low_gap", {31'b0, min_low >= 1}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
